// File: rtl/mem_nrd_pkg.sv
// Shared types and the byte-lane merge used by
// both the array write path and the read bypass.
package mem_nrd_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int MAXW = 1024;
    localparam int MAXB = MAXW / 8;

    // Callers zero-extend into MAXW and slice the result back.
    function automatic logic [MAXW-1:0] byte_merge(
        input logic [MAXW-1:0] old,
        input logic [MAXW-1:0] nw,
        input logic [MAXB-1:0] be
    );
        logic [MAXW-1:0] r;
        r = old;
        for (int b = 0; b < MAXB; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_nrd_sweep.sv
// Zeroing sweeper: owns the SWEEP/RUN state, the sweep
// counter and the ready flag; emits the clear strobe.
module mem_nrd_sweep
    import mem_nrd_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          ready,
    output logic          swe,
    output logic [AW-1:0] swa
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] sc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SWEEP;
            sc    <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                SWEEP: begin
                    if (clr) begin
                        sc <= '0;
                    end else if (sc == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                        sc    <= '0;
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= SWEEP;
                        ready <= 1'b0;
                        sc    <= '0;
                    end
                end
                default: begin
                    state <= SWEEP;
                    ready <= 1'b0;
                    sc    <= '0;
                end
            endcase
        end
    end

    assign swe = (state == SWEEP);
    assign swa = sc;

endmodule

// File: rtl/mem_nrd_init.sv
// Multi-read-port memory with byte-enabled writes, registered
// write-first reads and a hardware zeroing sweep.
module mem_nrd_init
    import mem_nrd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic                 ready,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [NB-1:0]        wbe,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rvalid,
    output logic                 err
);

    localparam logic [AW:0] DEP = (AW + 1)'(DEPTH);

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] o,
        input logic [WIDTH-1:0] n,
        input logic [NB-1:0]    b
    );
        logic [MAXW-1:0] eo;
        logic [MAXW-1:0] en;
        logic [MAXW-1:0] r;
        logic [MAXB-1:0] eb;
        eo = '0;
        en = '0;
        eb = '0;
        eo[WIDTH-1:0] = o;
        en[WIDTH-1:0] = n;
        eb[NB-1:0]    = b;
        r = byte_merge(eo, en, eb);
        return r[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic             swe;
    logic [AW-1:0]    swa;
    logic             winr;
    logic             wbad;
    logic [NRD-1:0]   rbad;

    mem_nrd_sweep #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sweep (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .ready (ready),
        .swe   (swe),
        .swa   (swa)
    );

    assign winr = ({1'b0, wa} < DEP);
    assign wbad = ready && we && !winr;

    // Sweep owns the write port; user writes only land in RUN.
    always_ff @(posedge clk) begin
        if (swe) begin
            mem[swa] <= '0;
        end else if (we && winr) begin
            mem[wa] <= merge(mem[wa], wd, wbe);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic             inr;
        logic             hit;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] rd_q;
        logic             v_q;

        assign a   = ra[i*AW +: AW];
        assign inr = ({1'b0, a} < DEP);
        assign hit = we && (wa == a);
        assign q   = inr ? mem[a] : '0;
        assign nxt = !inr ? '0 :
                     hit  ? merge(q, wd, wbe) : q;

        assign rbad[i] = ready && re[i] && !inr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
                v_q  <= 1'b0;
            end else if (!ready) begin
                rd_q <= '0;
                v_q  <= 1'b0;
            end else begin
                v_q <= re[i];
                if (re[i]) rd_q <= nxt;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = rd_q;
        assign rvalid[i]            = v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (!ready || clr) begin
            err <= 1'b0;
        end else if (wbad || (|rbad)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_nrd_init.sv
// Directed bench: a 32-word and a 20-word instance
// share one stimulus stream.
module tb_mem_nrd_init;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        we    = 1'b0;
    logic [4:0]  wa    = '0;
    logic [31:0] wd    = '0;
    logic [3:0]  wbe   = '0;
    logic [1:0]  re    = '0;
    logic [9:0]  ra    = '0;

    logic        rdy0, rdy1;
    logic [63:0] rd0, rd1;
    logic [1:0]  rv0, rv1;
    logic        err0, err1;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    mem_nrd_init u0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .ready  (rdy0),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .wbe    (wbe),
        .re     (re),
        .ra     (ra),
        .rd     (rd0),
        .rvalid (rv0),
        .err    (err0)
    );

    mem_nrd_init #(.DEPTH(20)) u1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .ready  (rdy1),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .wbe    (wbe),
        .re     (re),
        .ra     (ra),
        .rd     (rd1),
        .rvalid (rv1),
        .err    (err1)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic rdports(input int a0, input int a1,
                           input logic [1:0] en);
        re = en;
        ra = {5'(a1), 5'(a0)};
    endtask

    task automatic wr(input int a, input logic [31:0] d,
                      input logic [3:0] be);
        we  = 1'b1;
        wa  = 5'(a);
        wd  = d;
        wbe = be;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_ready",  64'(rdy0), 64'd0);
        chk("rst_rvalid", 64'(rv0),  64'd0);
        chk("rst_rd",     rd0,       64'd0);
        chk("rst_err",    64'(err0), 64'd0);

        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick;
            if (e < 32) chk("boot_ready_lo", 64'(rdy0), 64'd0);
            else        chk("boot_ready_hi", 64'(rdy0), 64'd1);
        end
        chk("u1_ready", 64'(rdy1), 64'd1);

        for (int a = 0; a < 32; a += 2) begin
            rdports(a, a + 1, 2'b11);
            tick;
            chk("init_rd", rd0,      64'd0);
            chk("init_rv", 64'(rv0), 64'd3);
        end
        re = 2'b00;

        wr(2, 32'hDEADBEEF, 4'hF);
        tick;
        we = 1'b0;
        rdports(2, 4, 2'b11);
        tick;
        chk("basic_rd", rd0,      64'h00000000_DEADBEEF);
        chk("basic_rv", 64'(rv0), 64'd3);

        re = 2'b00;
        tick;
        chk("hold_rv", 64'(rv0), 64'd0);
        chk("hold_rd", rd0,      64'h00000000_DEADBEEF);

        wr(2, 32'h11223344, 4'b0101);
        rdports(2, 0, 2'b01);
        tick;
        we = 1'b0;
        chk("bypass_rd", rd0,      64'h00000000_DE22BE44);
        chk("bypass_rv", 64'(rv0), 64'd1);

        rdports(2, 2, 2'b11);
        tick;
        chk("shared_rd", rd0, 64'hDE22BE44_DE22BE44);

        wr(2, 32'hFFFFFFFF, 4'b0000);
        rdports(2, 0, 2'b01);
        tick;
        we = 1'b0;
        chk("wbe0_rd", rd0[31:0], 64'hDE22BE44);

        re = 2'b00;
        wr(3, 32'hCAFEF00D, 4'hF);
        tick;
        we = 1'b0;
        rdports(3, 0, 2'b01);
        tick;
        chk("wr_then_rd", rd0[31:0], 64'hCAFEF00D);

        re = 2'b00;
        wr(25, 32'hFFFFFFFF, 4'hF);
        tick;
        we = 1'b0;
        chk("oor_wr_err", 64'(err1), 64'd1);
        chk("pow2_err",   64'(err0), 64'd0);

        rdports(25, 2, 2'b11);
        tick;
        chk("oor_rd",     rd1,       64'hDE22BE44_00000000);
        chk("oor_rv",     64'(rv1),  64'd3);
        chk("oor_err",    64'(err1), 64'd1);
        chk("pow2_rd25",  rd0[31:0], 64'hFFFFFFFF);

        rdports(5, 19, 2'b11);
        tick;
        chk("oor_nowr", rd1, 64'd0);

        re  = 2'b00;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_err",   64'(err1), 64'd0);
        chk("clr_ready", 64'(rdy0), 64'd0);
        repeat (31) tick;
        chk("clr_ready_lo", 64'(rdy0), 64'd0);
        tick;
        chk("clr_ready_hi", 64'(rdy0), 64'd1);

        for (int a = 0; a < 32; a++) begin
            wr(a, 32'hA5A5A5A5, 4'hF);
            tick;
        end
        we = 1'b0;
        rdports(0, 31, 2'b11);
        tick;
        chk("fill_rd", rd0, 64'hA5A5A5A5_A5A5A5A5);

        re  = 2'b00;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("sw_ready0", 64'(rdy0), 64'd0);
        chk("sw_rv0",    64'(rv0),  64'd0);
        for (int k = 1; k <= 32; k++) begin
            wr(k, 32'hFFFFFFFF, 4'hF);
            rdports(k, k, 2'b11);
            tick;
            chk("sw_rv", 64'(rv0), 64'd0);
            chk("sw_rd", rd0,      64'd0);
            if (k < 32) chk("sw_ready_lo", 64'(rdy0), 64'd0);
            else        chk("sw_ready_hi", 64'(rdy0), 64'd1);
        end
        we = 1'b0;
        re = 2'b00;

        for (int a = 0; a < 32; a += 2) begin
            rdports(a, a + 1, 2'b11);
            tick;
            chk("post_clr_rd", rd0, 64'd0);
        end
        re = 2'b00;

        wr(7, 32'hDEADBEEF, 4'hF);
        tick;
        we = 1'b0;
        rdports(7, 0, 2'b01);
        tick;
        chk("pre_rst_rd", rd0[31:0], 64'hDEADBEEF);
        chk("pre_rst_rv", 64'(rv0),  64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(rdy0), 64'd0);
        chk("arst_rv",    64'(rv0),  64'd0);
        chk("arst_rd",    rd0,       64'd0);
        chk("arst_err",   64'(err0), 64'd0);
        re = 2'b00;
        @(negedge clk);
        tick;
        rst_n = 1'b1;

        repeat (10) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("msw_ready", 64'(rdy0), 64'd0);
        chk("msw_rd",    rd0,       64'd0);
        @(negedge clk);
        tick;
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick;
            if (e < 32) chk("resweep_lo", 64'(rdy0), 64'd0);
            else        chk("resweep_hi", 64'(rdy0), 64'd1);
        end

        rdports(7, 0, 2'b01);
        tick;
        chk("resweep_rd7", rd0[31:0], 64'd0);
        re = 2'b00;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mem_nrd_init.md
# mem_nrd_init

Parametrised multi-read-port synchronous memory: the next generation of the 32x32 two-address memory. It adds configurable width, depth and read-port count, byte-enabled writes, registered reads with write-first bypass, and a hardware zeroing sweep after reset or on request. It sits as the data or register store behind the datapath; consumers wait for `ready` before issuing traffic.

## Interface
- `WIDTH`, 32, data width in bits; must be a multiple of 8.
- `DEPTH`, 32, number of words; any value ≥ 2, power of two not required.
- `NRD`, 2, number of independent read ports, ≥ 1.
- `AW`, `$clog2(DEPTH)`, address width; derived, not overridden.
- `clk`  in  1  clock; all activity on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clr`  in  1  synchronous request to re-zero the whole array and clear `err`.
- `ready`  out  1  high when the array is usable; low during a sweep.
- `we`  in  1  write enable.
- `wa`  in  AW  write address.
- `wd`  in  WIDTH  write data.
- `wbe`  in  WIDTH/8  byte enables; bit b covers `wd[8b+7:8b]`.
- `re`  in  NRD  per-port read enable.
- `ra`  in  NRD*AW  packed read addresses; port i is `ra[i*AW +: AW]`.
- `rd`  out  NRD*WIDTH  packed read data; port i is `rd[i*WIDTH +: WIDTH]`.
- `rvalid`  out  NRD  per-port read-data valid.
- `err`  out  1  sticky flag for an out-of-range access.

## Operation
- Two-state FSM:
  - SWEEP: a counter `sc` writes 0 to `mem[sc]` each cycle and runs 0 to DEPTH-1.
  - RUN: normal access.
- Transitions:
  - `rst_n` low: asynchronously forces SWEEP with `sc`=0.
  - SWEEP: moves to RUN on the edge that writes `sc`=DEPTH-1.
  - RUN with `clr`=1: next state SWEEP, `sc`=0.
  - `clr`=1 during SWEEP: restarts `sc` at 0.
- The array itself has no reset; only the sweep clears it.
- During SWEEP:
  - `we` and `re` are ignored.
  - `rvalid`=0 and `rd` holds 0.
  - `err` is cleared on entry.
- Write in RUN: `we`=1 and `wa`<DEPTH updates only the bytes with `wbe` set. `wbe`=0 is a legal no-op.
- Read in RUN: `re[i]`=1 and `ra_i`<DEPTH gives `rd_i` = `mem[ra_i]` on the next edge and `rvalid[i]`=1. All NRD ports are independent and may share an address.
- Write-first bypass: if the same cycle has `we`=1 and `wa`==`ra_i`:
  - enabled bytes of `rd_i` come from `wd`;
  - the other bytes come from the old content.
- Out-of-range: only possible when DEPTH is not a power of two.
  - A write to `wa`≥DEPTH is dropped.
  - A read from `ra_i`≥DEPTH returns 0 with `rvalid[i]`=1.
  - Either case sets `err`, which stays set until `clr` or reset.
- `re[i]`=0: `rvalid[i]`=0 next cycle and `rd_i` holds its last value.

## Timing
- Reset values (while `rst_n`=0): `ready`=0, `rvalid`=0, `rd`=0, `err`=0, state SWEEP, `sc`=0.
- After `rst_n` rises, `ready` goes high after the DEPTH-th rising edge. With the default this is edge 32.
- `clr` sampled high in RUN: `ready` drops after that edge and rises DEPTH edges later.
- Read latency is 1 cycle, with bypass included. Write latency is 1 cycle: a read issued on the edge after a write sees the new data.
- `clr` and `we` in the same RUN cycle: the write is performed, then the sweep zeroes it.
- `rst_n` asserted mid-sweep or mid-access: immediate return to reset values. A write in flight is not guaranteed.
- No combinational path from any input to any output.

## Structure
- Package `mem_nrd_pkg` holds:
  - the `state_t` enum (SWEEP, RUN);
  - the function `byte_merge(old, new, be)` used by both the write path and the bypass.
- Sub-module `mem_nrd_sweep` holds the state register, the `sc` counter, `ready`, and the sweep write strobe and address. The top level muxes sweep writes against user writes.
- Read ports are built with a generate loop over NRD.

## Test plan
- Reset then wait: hold `rst_n`=0 for 3 cycles, release.
  - `ready`=0 for edges 1–31 and `ready`=1 after edge 32.
  - Reading addresses 0–31 then returns 0x00000000.
- Basic write/read: write 0xDEADBEEF to address 2 with `wbe`=4'hF, then port0 reads 2 and port1 reads 4.
  - Next cycle: `rd_0`=0xDEADBEEF, `rd_1`=0, `rvalid`=2'b11.
- Byte enables and bypass: address 2 holds 0xDEADBEEF. Write 0x11223344 with `wbe`=4'b0101 while port0 reads 2 in the same cycle.
  - `rd_0`=0xDE22BE44 one cycle later.
- Out-of-range: with DEPTH=20, write 0xFFFFFFFF to address 25, then read 25.
  - `rd`=0, `rvalid`=1, `err`=1, and no other word changes.
  - `clr` then clears `err`.
- Clear mid-operation: fill all words with 0xA5A5A5A5, pulse `clr` for 1 cycle, and issue `re`/`we` during the sweep.
  - `ready`=0 for 32 edges and `rvalid` stays 0.
  - Afterwards every word reads 0.
- Async reset mid-sweep: drop `rst_n` between clock edges at `sc`=10.
  - Outputs reach reset values immediately.
  - After release, a full 32-cycle sweep runs again.
